opr_executor: RTL and testbench
===============================

Name: opr_executor

Overview:
- Sequential executor for PDP-8 operate (OPR) microinstructions.
- On START it takes IR and the current AC/L/MQ/SR values and performs the microoperations in architectural order, one step per clock.
- It returns new AC/L/MQ plus SKIP/HALT, and signals completion with a DONE pulse.
- It sits between the instruction-fetch/IR logic and the register file. Bit decoding is internal, and IR[0] is the PDP-8 least-significant bit (IAC position).

Parameters:
- EAE_EN, 1: 1 = group-3 MQ ops (MQA/MQL/SWP) execute; 0 = group 3 executes CLA only and flags ILLOP.
- HALT_STICKY, 1: 1 = HALT held until the next START; 0 = HALT is a one-cycle pulse with DONE.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  request. Sampled only in IDLE; the IR/AC_IN/L_IN/MQ_IN/SR snapshot is taken on that edge.
- IR  in  12  instruction word.
- AC_IN  in  12  accumulator.
- L_IN  in  1  link.
- MQ_IN  in  12  MQ register.
- SR  in  12  switch register.
- AC_OUT  out  12  result AC.
- L_OUT  out  1  result link.
- MQ_OUT  out  12  result MQ.
- SKIP  out  1  group-2 skip decision; valid with DONE.
- HALT  out  1  HLT executed.
- BUSY  out  1  high from the accept edge through the final step.
- DONE  out  1  one-cycle pulse; results valid.
- ILLOP  out  1  unsupported encoding seen; valid with DONE.

Behaviour:
- Reset: every output is 0 and the FSM enters IDLE. Reset asserted mid-operation aborts the operation; no DONE is produced.
- States: IDLE, S1, S2, S3, S4, S5.
  - E0 is the accept edge.
  - Step k updates working registers at edge Ek.
  - DONE/ILLOP/SKIP/HALT are registered at the last step's edge, so they are visible in the following cycle, and the FSM returns to IDLE at that edge.
  - START is accepted in the DONE cycle (back-to-back operation).
  - START while BUSY is ignored.
- AC_OUT/L_OUT/MQ_OUT hold their last results until the next operation's final edge. Intermediate steps update the internal working copies only.
- IR[11:9] != 7: no register change; DONE at E1; ILLOP = 1.
- Group 1 (IR[8] = 0), 4 steps (5 when rotating twice):
  - S1: CLA (IR[7]) AC = 0; CLL (IR[6]) L = 0.
  - S2: CMA (IR[5]) AC = ~AC; CML (IR[4]) L = ~L.
  - S3: IAC (IR[0]) {L,AC} = {L,AC} + 1 as a 13-bit add; the carry out of AC complements L, e.g. L=0, AC=7777 gives L=1, AC=0000.
  - S4: rotate the 13-bit {L,AC} right (IR[3]) or left (IR[2]) by one.
    - IR[1] with exactly one direction bit set rotates again in S5.
    - IR[1] with IR[3:2] = 0 is BSW: AC = {AC[5:0], AC[11:6]}, L unchanged.
    - IR[3] and IR[2] both set: no rotate; ILLOP = 1.
- Group 2 (IR[8] = 1, IR[0] = 0), 3 steps:
  - S1: skip is evaluated on the pre-CLA AC.
    - Sensed terms: C = (IR[6] & AC[11]) | (IR[5] & AC == 0) | (IR[4] & L).
    - SKIP = IR[3] ? ~C : C, so IR[3] alone means unconditional skip.
    - CLA (IR[7]) is applied after evaluation.
  - S2: OSR (IR[2]) AC = AC | SR.
  - S3: HLT (IR[1]) sets HALT.
- Group 3 (IR[8] = 1, IR[0] = 1), 2 steps:
  - S1: CLA (IR[7]).
  - S2 when EAE_EN = 1:
    - MQA & MQL (SWP): AC and MQ exchange.
    - MQA only: AC = AC | MQ.
    - MQL only: MQ = AC, AC = 0.
  - S2 when EAE_EN = 0: MQ ops skipped; ILLOP = 1 if IR[6] or IR[4] is set.
  - SCA (IR[5]) or IR[3:1] != 0: ignored; ILLOP = 1.
- SKIP is 0 for groups 1 and 3. HALT is 0 for groups 1 and 3.
- All arithmetic is modulo 2^12 on AC; L is bit 12 of rotates and adds.

Decomposition:
- Shared package holds:
  - the IR bit-position constants for all three groups;
  - the FSM state enum;
  - a 13-bit {L,AC} typedef;
  - the group-select encoding.
- One natural sub-module, opr_alu_step: a combinational single-step datapath taking (step, IR, AC, L, MQ, SR) and returning the next AC/L/MQ/skip. The FSM wrapper owns the registers and the handshake.

Test Plan:
- AC=7777 L=1, IR=7201 (CLA IAC) -> AC_OUT=0001, L_OUT=1, DONE at E4, ILLOP=0. Repeat with AC=7777 L=0, IR=7001 -> AC=0000, L=1.
- AC=0001 L=1, IR=7006 (RTL) -> AC=0006, L=0, DONE at E5. AC=0077, IR=7002 (BSW) -> AC=7700, DONE at E4.
- AC=0000, IR=7440 (SZA) -> SKIP=1, AC unchanged. IR=7450 (SNA) -> SKIP=0. IR=7410 -> SKIP=1. AC=1234 SR=0070, IR=7604 (CLA OSR) -> AC=0070. IR=7402 -> HALT=1, DONE at E3.
- AC=1234 MQ=5670, IR=7521 (SWP) -> AC=5670, MQ=1234, DONE at E2. IR=7421 (MQL) -> MQ=1234, AC=0000. EAE_EN=0 -> MQ unchanged, ILLOP=1.
- START held high across an operation -> exactly one DONE per accepted START; a second START in the DONE cycle is accepted. IR=7014 -> ILLOP=1.
- RESET_N low at E2 of IR=7201 -> all outputs 0, BUSY=0, no DONE. After release, START with IR=7001 AC=0005 -> AC=0006.

Source files
------------

// File: rtl/opr_executor_pkg.sv
// Shared definitions for the PDP-8 operate-instruction executor:
// IR bit positions, FSM state codes, group encoding and {L,AC} type.
package opr_executor_pkg;

    typedef logic [12:0] lac_t;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_S1   = 3'd1;
    localparam logic [2:0] ST_S2   = 3'd2;
    localparam logic [2:0] ST_S3   = 3'd3;
    localparam logic [2:0] ST_S4   = 3'd4;
    localparam logic [2:0] ST_S5   = 3'd5;

    localparam logic [1:0] GRP_ILL = 2'd0;
    localparam logic [1:0] GRP_1   = 2'd1;
    localparam logic [1:0] GRP_2   = 2'd2;
    localparam logic [1:0] GRP_3   = 2'd3;

    localparam int G1_CLA = 7;
    localparam int G1_CLL = 6;
    localparam int G1_CMA = 5;
    localparam int G1_CML = 4;
    localparam int G1_RAR = 3;
    localparam int G1_RAL = 2;
    localparam int G1_TWO = 1;
    localparam int G1_IAC = 0;

    localparam int G2_CLA = 7;
    localparam int G2_SMA = 6;
    localparam int G2_SZA = 5;
    localparam int G2_SNL = 4;
    localparam int G2_REV = 3;
    localparam int G2_OSR = 2;
    localparam int G2_HLT = 1;

    localparam int G3_CLA = 7;
    localparam int G3_MQA = 6;
    localparam int G3_SCA = 5;
    localparam int G3_MQL = 4;

    function automatic logic [1:0] grp_of(input logic [11:0] ir);
        if (ir[11:9] != 3'b111) return GRP_ILL;
        if (!ir[8])             return GRP_1;
        if (!ir[0])             return GRP_2;
        return GRP_3;
    endfunction

endpackage

// File: rtl/opr_executor_alu_step.sv
// One architectural step of an OPR microinstruction, purely combinational.
// Reports whether the given step is the final one for this encoding.
module opr_alu_step
    import opr_executor_pkg::*;
#(
    parameter logic EAE_EN = 1'b1
) (
    input  logic [2:0]  step,
    input  logic [11:0] ir,
    input  logic [11:0] ac,
    input  logic        l,
    input  logic [11:0] mq,
    input  logic [11:0] sr,
    output logic [11:0] ac_o,
    output logic        l_o,
    output logic [11:0] mq_o,
    output logic        skip_o,
    output logic        halt_o,
    output logic        ill_o,
    output logic        last_o
);

    lac_t lac;
    logic sense;

    assign lac = {l, ac};

    always_comb begin
        ac_o   = ac;
        l_o    = l;
        mq_o   = mq;
        skip_o = 1'b0;
        halt_o = 1'b0;
        ill_o  = 1'b0;
        last_o = 1'b0;
        sense  = (ir[G2_SMA] & ac[11]) | (ir[G2_SZA] & (ac == 12'd0))
               | (ir[G2_SNL] & l);
        case (grp_of(ir))
            GRP_ILL: begin
                ill_o  = 1'b1;
                last_o = 1'b1;
            end
            GRP_1: begin
                case (step)
                    ST_S1: begin
                        if (ir[G1_CLA]) ac_o = 12'd0;
                        if (ir[G1_CLL]) l_o = 1'b0;
                    end
                    ST_S2: begin
                        if (ir[G1_CMA]) ac_o = ~ac;
                        if (ir[G1_CML]) l_o = ~l;
                    end
                    ST_S3: begin
                        if (ir[G1_IAC]) {l_o, ac_o} = lac + 13'd1;
                    end
                    ST_S4, ST_S5: begin
                        priority case (1'b1)
                            ir[G1_RAR] & ir[G1_RAL]: ill_o = 1'b1;
                            ir[G1_RAR]: {l_o, ac_o} = {lac[0], lac[12:1]};
                            ir[G1_RAL]: {l_o, ac_o} = {lac[11:0], lac[12]};
                            ir[G1_TWO]: ac_o = {ac[5:0], ac[11:6]};
                            default: ;
                        endcase
                        // A second rotate only when exactly one direction is set
                        last_o = (step == ST_S5)
                               | ~(ir[G1_TWO] & (ir[G1_RAR] ^ ir[G1_RAL]));
                    end
                    default: ;
                endcase
            end
            GRP_2: begin
                case (step)
                    ST_S1: begin
                        skip_o = ir[G2_REV] ? ~sense : sense;
                        if (ir[G2_CLA]) ac_o = 12'd0;
                    end
                    ST_S2: begin
                        if (ir[G2_OSR]) ac_o = ac | sr;
                    end
                    ST_S3: begin
                        halt_o = ir[G2_HLT];
                        last_o = 1'b1;
                    end
                    default: ;
                endcase
            end
            GRP_3: begin
                case (step)
                    ST_S1: begin
                        if (ir[G3_CLA]) ac_o = 12'd0;
                    end
                    ST_S2: begin
                        last_o = 1'b1;
                        ill_o  = ir[G3_SCA] | (ir[3:1] != 3'd0);
                        if (EAE_EN) begin
                            case ({ir[G3_MQA], ir[G3_MQL]})
                                2'b11: begin
                                    ac_o = mq;
                                    mq_o = ac;
                                end
                                2'b10: ac_o = ac | mq;
                                2'b01: begin
                                    mq_o = ac;
                                    ac_o = 12'd0;
                                end
                                default: ;
                            endcase
                        end else if (ir[G3_MQA] | ir[G3_MQL]) begin
                            ill_o = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/opr_executor.sv
// Sequential PDP-8 OPR executor: snapshots operands on START and walks
// the microoperations one step per clock, publishing results with DONE.
module opr_executor
    import opr_executor_pkg::*;
#(
    parameter logic EAE_EN      = 1'b1,
    parameter logic HALT_STICKY = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        START,
    input  logic [11:0] IR,
    input  logic [11:0] AC_IN,
    input  logic        L_IN,
    input  logic [11:0] MQ_IN,
    input  logic [11:0] SR,
    output logic [11:0] AC_OUT,
    output logic        L_OUT,
    output logic [11:0] MQ_OUT,
    output logic        SKIP,
    output logic        HALT,
    output logic        BUSY,
    output logic        DONE,
    output logic        ILLOP
);

    logic [2:0]  state_q, state_d;
    logic [11:0] ir_q, ir_d, sr_q, sr_d;
    logic [11:0] ac_q, ac_d, mq_q, mq_d;
    logic        l_q, l_d, skip_q, skip_d, ill_q, ill_d;
    logic [11:0] ac_out_q, ac_out_d, mq_out_q, mq_out_d;
    logic        l_out_q, l_out_d, skip_out_q, skip_out_d;
    logic        halt_q, halt_d, busy_q, busy_d;
    logic        done_q, done_d, illop_q, illop_d;

    logic [11:0] a_ac, a_mq;
    logic        a_l, a_skip, a_halt, a_ill, a_last;

    opr_alu_step #(.EAE_EN(EAE_EN)) u_alu (
        .step   (state_q),
        .ir     (ir_q),
        .ac     (ac_q),
        .l      (l_q),
        .mq     (mq_q),
        .sr     (sr_q),
        .ac_o   (a_ac),
        .l_o    (a_l),
        .mq_o   (a_mq),
        .skip_o (a_skip),
        .halt_o (a_halt),
        .ill_o  (a_ill),
        .last_o (a_last)
    );

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        sr_d       = sr_q;
        ac_d       = ac_q;
        l_d        = l_q;
        mq_d       = mq_q;
        skip_d     = skip_q;
        ill_d      = ill_q;
        ac_out_d   = ac_out_q;
        l_out_d    = l_out_q;
        mq_out_d   = mq_out_q;
        skip_out_d = skip_out_q;
        illop_d    = illop_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        halt_d     = HALT_STICKY ? halt_q : 1'b0;
        if (state_q == ST_IDLE) begin
            if (START) begin
                state_d = ST_S1;
                busy_d  = 1'b1;
                ir_d    = IR;
                sr_d    = SR;
                ac_d    = AC_IN;
                l_d     = L_IN;
                mq_d    = MQ_IN;
                skip_d  = 1'b0;
                ill_d   = 1'b0;
                halt_d  = 1'b0;
            end
        end else begin
            ac_d   = a_ac;
            l_d    = a_l;
            mq_d   = a_mq;
            skip_d = skip_q | a_skip;
            ill_d  = ill_q | a_ill;
            if (a_last) begin
                state_d    = ST_IDLE;
                busy_d     = 1'b0;
                done_d     = 1'b1;
                ac_out_d   = a_ac;
                l_out_d    = a_l;
                mq_out_d   = a_mq;
                skip_out_d = skip_q | a_skip;
                illop_d    = ill_q | a_ill;
                halt_d     = a_halt;
            end else begin
                state_d = state_q + 3'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            ir_q       <= '0;
            sr_q       <= '0;
            ac_q       <= '0;
            l_q        <= 1'b0;
            mq_q       <= '0;
            skip_q     <= 1'b0;
            ill_q      <= 1'b0;
            ac_out_q   <= '0;
            l_out_q    <= 1'b0;
            mq_out_q   <= '0;
            skip_out_q <= 1'b0;
            illop_q    <= 1'b0;
            halt_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            sr_q       <= sr_d;
            ac_q       <= ac_d;
            l_q        <= l_d;
            mq_q       <= mq_d;
            skip_q     <= skip_d;
            ill_q      <= ill_d;
            ac_out_q   <= ac_out_d;
            l_out_q    <= l_out_d;
            mq_out_q   <= mq_out_d;
            skip_out_q <= skip_out_d;
            illop_q    <= illop_d;
            halt_q     <= halt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign AC_OUT = ac_out_q;
    assign L_OUT  = l_out_q;
    assign MQ_OUT = mq_out_q;
    assign SKIP   = skip_out_q;
    assign HALT   = halt_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign ILLOP  = illop_q;

endmodule

// File: tb/tb_opr_executor.sv
// Scoreboard bench for opr_executor: two instances (EAE on / sticky HALT,
// EAE off / pulsed HALT) share stimulus and are checked against a model.
module tb_opr_executor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] ir = '0, ac_in = '0, mq_in = '0, sr = '0;
    logic        l_in = 1'b0;

    logic [11:0] ac_a, mq_a, ac_b, mq_b;
    logic        l_a, skip_a, halt_a, busy_a, done_a, ill_a;
    logic        l_b, skip_b, halt_b, busy_b, done_b, ill_b;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic last_halt = 1'b0;
    logic prev_done_b = 1'b0;

    typedef struct {
        logic [11:0] ac;
        logic        l;
        logic [11:0] mq;
        logic        skip;
        logic        halt;
        logic        ill;
        int          steps;
        int          acc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    opr_executor #(.EAE_EN(1'b1), .HALT_STICKY(1'b1)) dut_a (
        .CLK(clk), .RESET_N(rst_n), .START(start), .IR(ir),
        .AC_IN(ac_in), .L_IN(l_in), .MQ_IN(mq_in), .SR(sr),
        .AC_OUT(ac_a), .L_OUT(l_a), .MQ_OUT(mq_a), .SKIP(skip_a),
        .HALT(halt_a), .BUSY(busy_a), .DONE(done_a), .ILLOP(ill_a)
    );

    opr_executor #(.EAE_EN(1'b0), .HALT_STICKY(1'b0)) dut_b (
        .CLK(clk), .RESET_N(rst_n), .START(start), .IR(ir),
        .AC_IN(ac_in), .L_IN(l_in), .MQ_IN(mq_in), .SR(sr),
        .AC_OUT(ac_b), .L_OUT(l_b), .MQ_OUT(mq_b), .SKIP(skip_b),
        .HALT(halt_b), .BUSY(busy_b), .DONE(done_b), .ILLOP(ill_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    function automatic exp_t model(input logic [11:0] i, input logic [11:0] a,
                                   input logic lk, input logic [11:0] m,
                                   input logic [11:0] s, input bit eae);
        exp_t e;
        int   lac;
        int   n;
        bit   c;
        logic [11:0] t;
        e.ac = a; e.l = lk; e.mq = m;
        e.skip = 1'b0; e.halt = 1'b0; e.ill = 1'b0;
        e.steps = 1; e.acc = 0;
        if (i[11:9] != 3'o7) begin
            e.ill = 1'b1;
        end else if (!i[8]) begin
            lac = (lk ? 4096 : 0) + int'(a);
            if (i[7]) lac = lac & 'h1000;
            if (i[6]) lac = lac & 'hFFF;
            if (i[5]) lac = lac ^ 'hFFF;
            if (i[4]) lac = lac ^ 'h1000;
            if (i[0]) lac = (lac + 1) % 8192;
            e.steps = 4;
            if (i[3] && i[2]) begin
                e.ill = 1'b1;
            end else if (i[3] || i[2]) begin
                n = i[1] ? 2 : 1;
                e.steps = 3 + n;
                for (int r = 0; r < n; r++) begin
                    if (i[3]) lac = (lac >> 1) | ((lac & 1) << 12);
                    else      lac = ((lac << 1) & 'h1FFF) | (lac >> 12);
                end
            end else if (i[1]) begin
                lac = (lac & 'h1000) | ((lac & 'h3F) << 6) | ((lac >> 6) & 'h3F);
            end
            e.ac = lac[11:0];
            e.l  = lac[12];
        end else if (!i[0]) begin
            e.steps = 3;
            c = (i[6] && a[11]) || (i[5] && a == 12'd0) || (i[4] && lk);
            e.skip = i[3] ? !c : c;
            e.ac = i[7] ? 12'd0 : a;
            if (i[2]) e.ac = e.ac | s;
            e.halt = i[1];
        end else begin
            e.steps = 2;
            e.ac = i[7] ? 12'd0 : a;
            e.ill = i[5] || (i[3:1] != 3'd0);
            if (eae) begin
                if (i[6] && i[4]) begin
                    t = e.ac; e.ac = m; e.mq = t;
                end else if (i[6]) begin
                    e.ac = e.ac | m;
                end else if (i[4]) begin
                    e.mq = e.ac; e.ac = 12'd0;
                end
            end else if (i[6] || i[4]) begin
                e.ill = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic check_res(input string tag, input exp_t e,
                             input logic [11:0] ac, input logic l,
                             input logic [11:0] mq, input logic sk,
                             input logic hl, input logic il);
        chk({tag, "_ac"},   int'(ac), int'(e.ac));
        chk({tag, "_l"},    int'(l),  int'(e.l));
        chk({tag, "_mq"},   int'(mq), int'(e.mq));
        chk({tag, "_skip"}, int'(sk), int'(e.skip));
        chk({tag, "_halt"}, int'(hl), int'(e.halt));
        chk({tag, "_ill"},  int'(il), int'(e.ill));
        chk({tag, "_lat"},  cyc - e.acc, e.steps);
    endtask

    // Monitor: pops one expectation per DONE pulse
    always @(negedge clk) begin
        exp_t e;
        if (done_a) begin
            if (q_a.size() == 0) chk("spurious_done_a", 1, 0);
            else begin
                e = q_a.pop_front();
                check_res("a", e, ac_a, l_a, mq_a, skip_a, halt_a, ill_a);
            end
        end
        if (done_b) begin
            if (q_b.size() == 0) chk("spurious_done_b", 1, 0);
            else begin
                e = q_b.pop_front();
                check_res("b", e, ac_b, l_b, mq_b, skip_b, halt_b, ill_b);
            end
        end
        if (prev_done_b && !done_b) chk("halt_b_pulse", int'(halt_b), 0);
        prev_done_b <= done_b;
    end

    // Called at a negedge; leaves the bench at the negedge showing DONE
    task automatic issue(input logic [11:0] i, input logic [11:0] a,
                         input logic lk, input logic [11:0] m,
                         input logic [11:0] s, input bit hold);
        exp_t ea, eb;
        bit ok;
        ir = i; ac_in = a; l_in = lk; mq_in = m; sr = s;
        start = 1'b1;
        ea = model(i, a, lk, m, s, 1'b1);
        eb = model(i, a, lk, m, s, 1'b0);
        @(posedge clk);
        @(negedge clk);
        ea.acc = cyc; eb.acc = cyc;
        q_a.push_back(ea);
        q_b.push_back(eb);
        chk("busy_after_accept", int'(busy_a), 1);
        ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (hold) begin
                ir = 12'($urandom); ac_in = 12'($urandom);
                mq_in = 12'($urandom); sr = 12'($urandom);
                l_in = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done_a) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("done_timeout", 0, 1);
        last_halt = ea.halt;
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        ir = 12'($urandom);
        @(negedge clk);
        chk("halt_a_sticky", int'(halt_a), int'(last_halt));
        chk("busy_idle", int'(busy_a), 0);
        for (int k = 1; k < n; k++) @(negedge clk);
    endtask

    logic [11:0] ri;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ac", int'(ac_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_halt", int'(halt_a), 0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(12'o7201, 12'o7777, 1'b1, 12'o0, 12'o0, 1'b0); idle(1);
        issue(12'o7001, 12'o7777, 1'b0, 12'o0, 12'o0, 1'b0); idle(1);
        issue(12'o7006, 12'o0001, 1'b1, 12'o0, 12'o0, 1'b0); idle(1);
        issue(12'o7002, 12'o0077, 1'b0, 12'o0, 12'o0, 1'b0); idle(1);
        issue(12'o7440, 12'o0000, 1'b0, 12'o0, 12'o0, 1'b0); idle(1);
        issue(12'o7450, 12'o0000, 1'b0, 12'o0, 12'o0, 1'b0); idle(1);
        issue(12'o7410, 12'o0000, 1'b0, 12'o0, 12'o0, 1'b0); idle(1);
        issue(12'o7604, 12'o1234, 1'b0, 12'o0, 12'o0070, 1'b0); idle(1);
        issue(12'o7402, 12'o1234, 1'b0, 12'o0, 12'o0, 1'b0); idle(2);
        issue(12'o7521, 12'o1234, 1'b0, 12'o5670, 12'o0, 1'b0); idle(1);
        issue(12'o7421, 12'o1234, 1'b0, 12'o5670, 12'o0, 1'b0); idle(1);
        issue(12'o7201, 12'o4321, 1'b0, 12'o0, 12'o0, 1'b1);
        issue(12'o7014, 12'o1111, 1'b1, 12'o0, 12'o0, 1'b1);
        issue(12'o1234, 12'o2222, 1'b1, 12'o3333, 12'o0, 1'b0);
        issue(12'o7402, 12'o0707, 1'b1, 12'o6060, 12'o0, 1'b0);

        // Abort mid-operation with nonzero outputs and HALT set
        ir = 12'o7201; ac_in = 12'o7777; l_in = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ac", int'(ac_a), 0);
        chk("abort_l", int'(l_a), 0);
        chk("abort_mq", int'(mq_a), 0);
        chk("abort_halt", int'(halt_a), 0);
        chk("abort_busy", int'(busy_a), 0);
        chk("abort_done", int'(done_a), 0);
        chk("abort_skip", int'(skip_a), 0);
        chk("abort_ill", int'(ill_a), 0);
        last_halt = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(12'o7001, 12'o0005, 1'b0, 12'o0, 12'o0, 1'b0); idle(1);

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 7) == 0) ri = 12'($urandom);
            else ri = {3'b111, 9'($urandom)};
            issue(ri, 12'($urandom), 1'($urandom), 12'($urandom),
                  12'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(3);
        chk("queue_a_empty", q_a.size(), 0);
        chk("queue_b_empty", q_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
